// File: rtl/fptofix_if.sv
// Handshake bundle for the float-to-fixed converter: operand side and result side.
interface fptofix_if #(
  parameter int WOUT = 32
);
  logic [31:0]     a;
  logic [1:0]      roundmode;
  logic            in_valid;
  logic            in_ready;
  logic [WOUT-1:0] q;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      flags;

  modport master (
    output a, roundmode, in_valid, out_ready,
    input  in_ready, q, out_valid, flags
  );

  modport slave (
    input  a, roundmode, in_valid, out_ready,
    output in_ready, q, out_valid, flags
  );
endinterface

// File: rtl/fptofix.sv
// Multi-cycle IEEE single to signed fixed-point converter; magnitude shifted one bit
// per cycle, then rounded, saturated and negated. One operand in flight at a time.
module fptofix #(
  parameter int WOUT = 32,
  parameter int FRAC = 16
) (
  input logic       clk,
  input logic       reset,
  fptofix_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t state, state_next;

  logic [31:0]     a_r;
  logic [1:0]      rm_r;
  logic            s;
  logic [WOUT-1:0] mag;
  logic            g, t;
  logic [7:0]      cnt;
  logic            left;
  logic            ovf, inv;
  logic [WOUT-1:0] q_r;
  logic [2:0]      flags_r;

  logic            accept;

  // Unpack decode of the captured operand
  logic [7:0]  e;
  logic [22:0] f;
  logic [23:0] m;
  logic [7:0]  ee;
  int          k;
  logic        is_nan, is_inf, is_zero;
  logic [7:0]  n_u;

  always_comb begin
    e       = a_r[30:23];
    f       = a_r[22:0];
    m       = {(e != 8'd0), f};
    ee      = (e == 8'd0) ? 8'd1 : e;
    k       = int'(ee) - 150 + FRAC;
    is_nan  = (e == 8'hFF) && (f != 23'd0);
    is_inf  = (e == 8'hFF) && (f == 23'd0);
    is_zero = (e == 8'd0) && (f == 23'd0);
    if (is_nan || is_inf || is_zero) begin
      n_u = '0;
    end else if (k < 0) begin
      n_u = (-k > 26) ? 8'd26 : 8'(-k);
    end else begin
      n_u = 8'(k);
    end
  end

  // Rounding, saturation and negation of the shifted magnitude
  logic            inc;
  logic [WOUT:0]   sum;
  logic [WOUT:0]   pos_max, neg_max;
  logic            rnd_ovf, ovf_all, inexact;
  logic [WOUT-1:0] q_next;

  always_comb begin
    case (rm_r)
      2'b00:   inc = g & (t | mag[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~s & (g | t);
      default: inc = s & (g | t);
    endcase
    sum     = {1'b0, mag} + {{WOUT{1'b0}}, inc};
    pos_max = {2'b00, {(WOUT-1){1'b1}}};
    neg_max = {2'b01, {(WOUT-1){1'b0}}};
    rnd_ovf = s ? (sum > neg_max) : (sum > pos_max);
    ovf_all = (ovf | rnd_ovf) & ~inv;
    inexact = (g | t) & ~ovf_all & ~inv;
    if (inv) begin
      q_next = '0;
    end else if (ovf_all) begin
      q_next = s ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
    end else if (s) begin
      q_next = -sum[WOUT-1:0];
    end else begin
      q_next = sum[WOUT-1:0];
    end
  end

  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.in_ready  = (state == IDLE) & ~reset;
  assign bus.out_valid = (state == DONE);
  assign bus.q         = q_r;
  assign bus.flags     = flags_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = UNPACK;
      UNPACK:  state_next = (n_u == 8'd0) ? ROUND : SHIFT;
      // A left shift that would push a one out of the top bit saturates immediately
      SHIFT:   if ((left && mag[WOUT-1]) || cnt == 8'd1) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      rm_r    <= '0;
      s       <= 1'b0;
      mag     <= '0;
      g       <= 1'b0;
      t       <= 1'b0;
      cnt     <= '0;
      left    <= 1'b0;
      ovf     <= 1'b0;
      inv     <= 1'b0;
      q_r     <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r  <= bus.a;
            rm_r <= bus.roundmode;
          end
        end
        UNPACK: begin
          s    <= a_r[31];
          mag  <= {{(WOUT-24){1'b0}}, m};
          g    <= 1'b0;
          t    <= 1'b0;
          cnt  <= n_u;
          left <= (k > 0);
          ovf  <= is_inf;
          inv  <= is_nan;
        end
        SHIFT: begin
          if (left) begin
            if (mag[WOUT-1]) begin
              ovf <= 1'b1;
            end else begin
              mag <= mag << 1;
              cnt <= cnt - 8'd1;
            end
          end else begin
            t   <= t | g;
            g   <= mag[0];
            mag <= mag >> 1;
            cnt <= cnt - 8'd1;
          end
        end
        ROUND: begin
          q_r     <= q_next;
          flags_r <= {inv, ovf_all, inexact};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fptofix.sv
// Table-driven bench for fptofix with a scoreboard queue of expected results,
// plus hand sequences for output back-pressure and mid-conversion reset.
module tb_fptofix;

  logic clk;
  logic reset;

  fptofix_if #(.WOUT(32)) bus ();

  fptofix #(.WOUT(32), .FRAC(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    logic [31:0] q;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [1:0] rm, input logic [31:0] q,
                     input logic [2:0] fl, input int lat);
    vec_t v;
    v.a = a; v.rm = rm; v.q = q; v.fl = fl; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive one operand, wait for the result, compare against the scoreboard head.
  task automatic run_one(input vec_t v, input string tag);
    int   lat;
    int   w;
    vec_t e;
    sb.push_back(v);
    bus.a         = v.a;
    bus.roundmode = v.rm;
    bus.in_valid  = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.a         = $urandom;
    bus.roundmode = 2'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_q"}, 64'(bus.q), 64'(e.q));
      check({tag, "_flags"}, 64'(bus.flags), 64'(e.fl));
      if (e.lat != 0) check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    end
  endtask

  initial begin
    logic [31:0] hq;
    logic [2:0]  hf;
    vec_t        v;
    int          w;

    reset         = 1'b1;
    bus.a         = '0;
    bus.roundmode = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    add(32'h3F800000, 2'd0, 32'h00010000, 3'b000, 10);
    add(32'hC0200000, 2'd0, 32'hFFFD8000, 3'b000, 9);
    add(32'h3F800001, 2'd0, 32'h00010000, 3'b001, 10);
    add(32'h3F800001, 2'd2, 32'h00010001, 3'b001, 10);
    add(32'h3F800001, 2'd3, 32'h00010000, 3'b001, 10);
    add(32'h3F800001, 2'd1, 32'h00010000, 3'b001, 10);
    add(32'hBF800001, 2'd2, 32'hFFFF0000, 3'b001, 10);
    add(32'hBF800001, 2'd3, 32'hFFFEFFFF, 3'b001, 10);
    add(32'h37000000, 2'd0, 32'h00000000, 3'b001, 27);
    add(32'h37000000, 2'd2, 32'h00000001, 3'b001, 27);
    add(32'h37400000, 2'd0, 32'h00000001, 3'b001, 27);
    add(32'h37C00000, 2'd0, 32'h00000002, 3'b001, 26);
    add(32'h80000001, 2'd3, 32'hFFFFFFFF, 3'b001, 29);
    add(32'h43000000, 2'd0, 32'h00800000, 3'b000, 3);
    add(32'h43000001, 2'd1, 32'h00800001, 3'b000, 3);
    add(32'h46FFFE00, 2'd0, 32'h7FFF0000, 3'b000, 10);
    add(32'h47000000, 2'd0, 32'h7FFFFFFF, 3'b010, 0);
    add(32'hC7000000, 2'd0, 32'h80000000, 3'b000, 11);
    add(32'h4F000000, 2'd0, 32'h7FFFFFFF, 3'b010, 12);
    add(32'h7F800000, 2'd0, 32'h7FFFFFFF, 3'b010, 3);
    add(32'hFF800000, 2'd0, 32'h80000000, 3'b010, 3);
    add(32'h7FC00000, 2'd0, 32'h00000000, 3'b100, 3);
    add(32'h80000000, 2'd0, 32'h00000000, 3'b000, 3);
    add(32'h00000000, 2'd3, 32'h00000000, 3'b000, 3);

    repeat (3) @(posedge clk);
    #1;
    check("reset_q", 64'(bus.q), 64'd0);
    check("reset_flags", 64'(bus.flags), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Back-pressure: result must hold and new operands be ignored
    bus.out_ready = 1'b0;
    v.a = 32'h3F800000; v.rm = 2'd0; v.q = 32'h00010000; v.fl = 3'b000; v.lat = 10;
    run_one(v, "hold");
    hq = 32'h00010000;
    hf = 3'b000;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = $urandom | 32'h40000000;
      @(posedge clk); #1;
      check("hold_q", 64'(bus.q), 64'(hq));
      check("hold_flags", 64'(bus.flags), 64'(hf));
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    check("release_q_held", 64'(bus.q), 64'(hq));

    // Reset in the middle of a right shift
    bus.a         = 32'h3F800000;
    bus.roundmode = 2'd0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_q", 64'(bus.q), 64'd0);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("midreset_idle", 64'(bus.in_ready), 64'd1);
    w = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) w++;
    end
    check("midreset_discarded", 64'(w), 64'd0);
    v.a = 32'h3F800001; v.rm = 2'd2; v.q = 32'h00010001; v.fl = 3'b001; v.lat = 10;
    run_one(v, "after_reset");
    @(posedge clk); #1;

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
